stream_unzip: RTL

Splits one valid/ready input stream into two output streams by alternating elements: element 0 to A, element 1 to B, element 2 to A, and so on. It is the inverse of the two-input zip/combine stage. It sits between a producer of interleaved pairs and two independent consumers. Each output has its own registered slot, so a stalled consumer does not block the other output's pending element.

---
 rtl/stream_unzip_pkg.sv | 14 +
 rtl/stream_unzip_slot.sv | 78 +++++++
 rtl/stream_unzip.sv | 74 +++++++
 3 files changed

// File: rtl/stream_unzip_pkg.sv
// stream_unzip_pkg: shared width default and destination encoding for the
// stream_unzip slice. Optional build macro: STREAM_UNZIP_SKID_EN.
package stream_unzip_pkg;

  // Default stream data width.
  localparam int unsigned INT_N = 8;

  // Destination of the next accepted input element.
  typedef enum logic {
    DEST_A = 1'b0,
    DEST_B = 1'b1
  } dest_e;

endpackage

// File: rtl/stream_unzip_slot.sv
// stream_slot: one registered output slot of stream_unzip.
// When STREAM_UNZIP_SKID_EN is defined, the slot has a second (skid) register.
// can_load is then driven from a flop, so there is no combinational path
// from pop_ready to can_load.
module stream_slot
  import stream_unzip_pkg::*;
#(
  parameter int W = INT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         pop_ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         can_load
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         pop;

  assign pop   = main_valid && pop_ready;
  assign valid = main_valid;
  assign dout  = main_data;

`ifdef STREAM_UNZIP_SKID_EN
  logic         skid_valid;
  logic [W-1:0] skid_data;

  assign can_load = !skid_valid;

  // Main register refills from skid on pop; skid only catches loads into a full, stalled main.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (pop) begin
      if (skid_valid) begin
        // A load cannot coincide here because can_load is low while skid is full.
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else if (load) begin
        main_data <= din;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (load) begin
      if (!main_valid) begin
        main_valid <= 1'b1;
        main_data  <= din;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= din;
      end
    end
  end
`else
  assign can_load = !main_valid || pop_ready;

  // Single register: a load wins over a pop, and a bare pop clears valid while data holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (load) begin
      main_valid <= 1'b1;
      main_data  <= din;
    end else if (pop) begin
      main_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/stream_unzip.sv
// stream_unzip: splits one valid/ready stream into A (even-index elements)
// and B (odd-index elements) streams, each with its own registered slot.
// Optional build macro: STREAM_UNZIP_SKID_EN (adds a skid register per slot).
module stream_unzip
  import stream_unzip_pkg::*;
#(
  parameter int W = INT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sIn,
  input  logic         sIn_valid,
  output logic         sIn_ready,
  output logic [W-1:0] sOutA,
  output logic         sOutA_valid,
  input  logic         sOutA_ready,
  output logic [W-1:0] sOutB,
  output logic         sOutB_valid,
  input  logic         sOutB_ready,
  output logic         phase
);

  dest_e phase_q;
  logic  accept;
  logic  load_a;
  logic  load_b;
  logic  can_load_a;
  logic  can_load_b;

  // Input readiness follows only the slot that the next element is destined for.
  always_comb begin
    sIn_ready = 1'b0;
    if (!rst) begin
      sIn_ready = (phase_q == DEST_A) ? can_load_a : can_load_b;
    end
  end

  assign accept = sIn_valid && sIn_ready;
  assign load_a = accept && (phase_q == DEST_A);
  assign load_b = accept && (phase_q == DEST_B);
  assign phase  = phase_q;

  // Destination toggles on every accepted element; reset restarts at A.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= DEST_A;
    end else if (accept) begin
      phase_q <= (phase_q == DEST_A) ? DEST_B : DEST_A;
    end
  end

  stream_slot #(.W(W)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a),
    .din       (sIn),
    .pop_ready (sOutA_ready),
    .valid     (sOutA_valid),
    .dout      (sOutA),
    .can_load  (can_load_a)
  );

  stream_slot #(.W(W)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b),
    .din       (sIn),
    .pop_ready (sOutB_ready),
    .valid     (sOutB_valid),
    .dout      (sOutB),
    .can_load  (can_load_b)
  );

endmodule
